// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, control-bit bundle and helpers for the VGA scan
package vga_pkg;

    // Default 640x480@60 Hz horizontal timing in pixels
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;

    // Default vertical timing in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    // Hack screen window: 512x256 pixels, 32 words per line
    localparam int WIN_W        = 512;
    localparam int WIN_H        = 256;
    localparam int WIN_X0_DEF   = 64;
    localparam int WIN_Y0_DEF   = 112;
    localparam int SCR_WORDS    = 8192;
    localparam int SCR_AW       = $clog2(SCR_WORDS);
    localparam int RD_LAT_DEF   = 1;

    // Per-pixel control bits carried alongside the memory read
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       in_win;
        logic       frame;
        logic [3:0] bit_idx;
    } ctrl_t;

    // Inactive control word: syncs released, nothing visible
    localparam ctrl_t CTRL_IDLE = '{
        hsync:    1'b1,
        vsync:    1'b1,
        video_on: 1'b0,
        in_win:   1'b0,
        frame:    1'b0,
        bit_idx:  4'd0
    };

    // Half-open interval test lo <= x < hi
    function automatic logic in_range(input logic [10:0] x, input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register delay line with async reset to a given value
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift: each stage takes the previous one, stage 0 takes the input
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset flushes every stage to the inactive value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_screen_scan.sv
// rtl/vga_screen_scan.sv - VGA raster generator serialising the Hack screen into a centred window
module vga_screen_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int WIN_X0   = WIN_X0_DEF,
    parameter int WIN_Y0   = WIN_Y0_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic              clk_25,
    input  logic              rst,
    output logic [SCR_AW-1:0] scr_addr,
    input  logic [15:0]       scr_data,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              pix_on,
    output logic              frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] WX_LO  = 11'(WIN_X0);
    localparam logic [10:0] WX_HI  = 11'(WIN_X0 + WIN_W);
    localparam logic [10:0] WY_LO  = 11'(WIN_Y0);
    localparam logic [10:0] WY_HI  = 11'(WIN_Y0 + WIN_H);

    // Control bits must wait for the address register plus the memory latency
    localparam int CTRL_DEPTH = RD_LAT + 1;

    // S0 counters
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    // S0 decode
    logic [10:0] h_ext, v_ext;
    logic [8:0]  h_off;
    logic [7:0]  v_off;
    logic        win_s0;
    ctrl_t       ctrl_s0;
    ctrl_t       ctrl_dly;

    // S1 address register
    logic [SCR_AW-1:0] scr_addr_q, scr_addr_d;

    // Output stage registers
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic pix_on_q, pix_on_d;
    logic frame_start_q, frame_start_d;

    // Horizontal counter wraps at the line end and advances the line counter
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Decode the current position into a memory address and the control bits for that pixel
    always_comb begin
        h_ext  = {1'b0, h_q};
        v_ext  = {1'b0, v_q};
        h_off  = h_q[8:0] - 9'(WIN_X0);
        v_off  = v_q[7:0] - 8'(WIN_Y0);
        win_s0 = in_range(h_ext, WX_LO, WX_HI) && in_range(v_ext, WY_LO, WY_HI);

        ctrl_s0          = CTRL_IDLE;
        ctrl_s0.hsync    = !in_range(h_ext, H_SS, H_SE);
        ctrl_s0.vsync    = !in_range(v_ext, V_SS, V_SE);
        ctrl_s0.video_on = (h_ext < H_VIS) && (v_ext < V_VIS);
        ctrl_s0.in_win   = win_s0;
        ctrl_s0.frame    = (h_q == '0) && (v_q == '0);
        ctrl_s0.bit_idx  = h_off[3:0];

        scr_addr_d = win_s0 ? {v_off, h_off[8:4]} : '0;
    end

    // Address register feeding the screen memory
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            scr_addr_q <= '0;
        end else begin
            scr_addr_q <= scr_addr_d;
        end
    end

    assign scr_addr = scr_addr_q;

    vga_delay_line #(
        .WIDTH   ($bits(ctrl_t)),
        .DEPTH   (CTRL_DEPTH),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .clk  (clk_25),
        .rst  (rst),
        .din  (ctrl_s0),
        .dout (ctrl_dly)
    );

    // Pick the pixel bit from the returned word; Hack 1 is black, data ignored outside the window
    always_comb begin
        hsync_d       = ctrl_dly.hsync;
        vsync_d       = ctrl_dly.vsync;
        video_on_d    = ctrl_dly.video_on;
        frame_start_d = ctrl_dly.frame;
        pix_on_d      = 1'b0;
        if (ctrl_dly.in_win && ctrl_dly.video_on) begin
            pix_on_d = !scr_data[ctrl_dly.bit_idx];
        end
    end

    // Output registers, all five aligned to the same pixel
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pix_on_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_on_q      <= pix_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_on      = pix_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_screen_scan.sv
// tb/tb_vga_screen_scan.sv - scoreboard bench for the VGA screen scan with a short-frame configuration
module tb_vga_screen_scan;

    localparam int HT    = 800;
    localparam int VA    = 24;
    localparam int VT    = 32;
    localparam int FRAME = HT * VT;
    localparam int WX    = 64;
    localparam int WY    = 4;
    localparam int RDL   = 2;
    localparam int LAT   = RDL + 2;
    localparam logic [17:0] RST_VEC = {5'b11000, 13'd0};

    typedef struct {
        logic [17:0] exp;
        int          cyc;
        bit          in_rst;
    } sb_t;

    bit          clk = 1'b0;
    logic        rst;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        hsync, vsync, video_on, pix_on, frame_start;

    logic [15:0] mem [8192];
    logic [12:0] rd_pipe [RDL];

    sb_t sb_q [$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc_m = 0;
    bit  phase1 = 1'b0;

    int vid_rise [$], vid_fall [$], hs_fall [$], hs_rise [$];
    int vs_fall [$], vs_rise [$], fs_at [$];
    logic prev_vid = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;

    int tab_h [7] = '{64, 79, 80, 575, 63, 576, 575};
    int tab_v [7] = '{4, 4, 4, 31, 4, 4, 5};
    int tab_a [7] = '{0, 0, 1, 895, 0, 0, 63};

    vga_screen_scan #(
        .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
        .V_ACTIVE (VA),  .V_FP (2),  .V_SYNC (2),  .V_BP (4),
        .WIN_X0   (WX),  .WIN_Y0 (WY), .RD_LAT (RDL)
    ) dut (
        .clk_25      (clk),
        .rst         (rst),
        .scr_addr    (scr_addr),
        .scr_data    (scr_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pix_on      (pix_on),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Screen memory with RDL cycles of read latency
    always @(posedge clk) begin
        rd_pipe[0] <= scr_addr;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign scr_data = mem[rd_pipe[RDL-1]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [12:0] addr_of(input int n);
        int h, v;
        if (n < 0) return 13'd0;
        h = n % HT;
        v = (n / HT) % VT;
        if (h >= WX && h < WX + 512 && v >= WY && v < WY + 256)
            return 13'((v - WY) * 32 + (h - WX) / 16);
        return 13'd0;
    endfunction

    // Reference: outputs for cycle c after release describe pixel c-LAT; address describes c-1
    function automatic logic [17:0] expect_at(input int c);
        int   n, h, v;
        logic hs, vs, vid, px, fs;
        logic [15:0] w;
        if (c < LAT) return {5'b11000, addr_of(c - 1)};
        n   = c - LAT;
        h   = n % HT;
        v   = (n / HT) % VT;
        vid = (h < 640) && (v < VA);
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= VA + 2 && v < VA + 4);
        fs  = (n % FRAME) == 0;
        px  = 1'b0;
        if (vid && h >= WX && h < WX + 512 && v >= WY && v < WY + 256) begin
            w  = mem[(v - WY) * 32 + (h - WX) / 16];
            px = !w[(h - WX) % 16];
        end
        return {hs, vs, vid, px, fs, addr_of(c - 1)};
    endfunction

    // Model: push one expectation per clock
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (rst) begin
            cyc_m    = 0;
            e.exp    = RST_VEC;
            e.cyc    = 0;
            e.in_rst = 1'b1;
        end else begin
            cyc_m++;
            e.exp    = expect_at(cyc_m);
            e.cyc    = cyc_m;
            e.in_rst = 1'b0;
        end
        sb_q.push_back(e);
    end

    // Monitor: pop and compare on the falling edge
    always @(negedge clk) begin
        sb_t  e;
        logic [17:0] act;
        int n, h, v, k;
        act = {hsync, vsync, video_on, pix_on, frame_start, scr_addr};
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no expectation, expected one per cycle");
        end else begin
            e = sb_q.pop_front();
            check("scan", 64'(act), 64'(e.exp));
            if (!e.in_rst) begin
                n = e.cyc - LAT;
                if (n >= 0) begin
                    h = n % HT;
                    v = (n / HT) % VT;
                    if (v == WY && ((h >= 63 && h <= 95) || h == 576 || h == 639))
                        check($sformatf("pix_h%0d", h), 64'(pix_on),
                              64'((h >= 65 && h <= 80) ? 1 : 0));
                end
                k = e.cyc - 1;
                for (int i = 0; i < 7; i++) begin
                    if (k >= 0 && k % HT == tab_h[i] && (k / HT) % VT == tab_v[i])
                        check($sformatf("addr_h%0d_v%0d", tab_h[i], tab_v[i]),
                              64'(scr_addr), 64'(tab_a[i]));
                end
                if (phase1) begin
                    if (video_on && !prev_vid) vid_rise.push_back(e.cyc);
                    if (!video_on && prev_vid) vid_fall.push_back(e.cyc);
                    if (!hsync && prev_hs)     hs_fall.push_back(e.cyc);
                    if (hsync && !prev_hs)     hs_rise.push_back(e.cyc);
                    if (!vsync && prev_vs)     vs_fall.push_back(e.cyc);
                    if (vsync && !prev_vs)     vs_rise.push_back(e.cyc);
                    if (frame_start)           fs_at.push_back(e.cyc);
                end
            end
        end
        prev_vid = video_on;
        prev_hs  = hsync;
        prev_vs  = vsync;
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0001;
        mem[1] = 16'hFFFE;
        for (int i = 0; i < RDL; i++) rd_pipe[i] = '0;

        repeat (5) @(negedge clk);
        #2;
        rst    = 1'b0;
        phase1 = 1'b1;

        // Run into frame 2 and strike reset at h=300, v=10
        repeat (FRAME + 10 * HT + 300) @(negedge clk);
        phase1 = 1'b0;
        check("pre_rst_video_on", 64'(video_on), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 64'({hsync, vsync, video_on, pix_on, frame_start, scr_addr}),
              64'(RST_VEC));
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (11000) @(negedge clk);

        check("first_fs_cycle", 64'(qget(fs_at, 0)), 64'(LAT));
        check("fs_per_frame", 64'(fs_at.size()), 64'd2);
        check("frame_period", 64'(qget(fs_at, 1) - qget(fs_at, 0)), 64'(FRAME));
        check("line_period", 64'(qget(vid_rise, 1) - qget(vid_rise, 0)), 64'(HT));
        check("video_on_len", 64'(qget(vid_fall, 0) - qget(vid_rise, 0)), 64'd640);
        check("hsync_start", 64'(qget(hs_fall, 0) - qget(vid_rise, 0)), 64'd656);
        check("hsync_len", 64'(qget(hs_rise, 0) - qget(hs_fall, 0)), 64'd96);
        check("vsync_start", 64'(qget(vs_fall, 0) - qget(fs_at, 0)), 64'((VA + 2) * HT));
        check("vsync_len", 64'(qget(vs_rise, 0) - qget(vs_fall, 0)), 64'(2 * HT));
        check("vsync_pulses", 64'(vs_fall.size()), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
